alu_seq_driver: RTL

Sequential initiator for the 4-bit combinational ALU (`inA`, `inB`, `op` -> `ans`). It accepts operation requests over a valid/ready handshake, drives the ALU operand and opcode lines from registers, samples `ans` one cycle later, and queues results in a small FIFO for a downstream consumer. It sits between a command source (test sequencer or control FSM) and the ALU, replacing hand-timed stimulus with a handshaked request/response path.

---
 rtl/alu_seq_driver.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_seq_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_driver
// Purpose  : Handshaked request/response initiator for a 4-bit combinational
//            ALU. Results are queued in a small FIFO. Optional result checker
//            is built when ALU_SEQ_DRIVER_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_driver #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_a,
    input  logic [WIDTH-1:0]         req_b,
    input  logic [1:0]               req_op,
    output logic [WIDTH-1:0]         alu_inA,
    output logic [WIDTH-1:0]         alu_inB,
    output logic [1:0]               alu_op,
    input  logic [WIDTH-1:0]         alu_ans,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [1:0]               rsp_op,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_CW = C_AW + 1;
    localparam logic [C_CW-1:0] C_DEPTH_CNT = C_CW'(DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ina_q, ina_d;
    logic [WIDTH-1:0]   inb_q, inb_d;
    logic [1:0]         op_q, op_d;
    logic [C_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [C_CW-1:0]    count_q, count_d;
    logic [WIDTH+1:0]   fifo_mem_q [DEPTH];
    logic               w_push;
    logic               w_pop;
    logic               w_ready;

    always_comb begin
        state_d = state_q;
        ina_d   = ina_q;
        inb_d   = inb_q;
        op_d    = op_q;
        w_ready = 1'b0;
        w_push  = 1'b0;
        case (state_q)
            IDLE: begin
                w_ready = (count_q < C_DEPTH_CNT);
                if (req_valid && w_ready) begin
                    ina_d   = req_a;
                    inb_d   = req_b;
                    op_d    = req_op;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // ALU has had a full cycle to settle on the registered lines
                w_push  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_pop    = (count_q != '0) && rsp_ready;
        wr_ptr_d = w_push ? wr_ptr_q + C_AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + C_AW'(1) : rd_ptr_q;
        count_d  = count_q + {{(C_CW-1){1'b0}}, w_push} - {{(C_CW-1){1'b0}}, w_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ina_q    <= '0;
            inb_q    <= '0;
            op_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ina_q    <= ina_d;
            inb_q    <= inb_d;
            op_q     <= op_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone qualifies the head
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            fifo_mem_q[wr_ptr_q] <= {op_q, alu_ans};
        end
    end

    assign req_ready = w_ready;
    assign alu_inA   = ina_q;
    assign alu_inB   = inb_q;
    assign alu_op    = op_q;
    assign rsp_valid = (count_q != '0);
    assign rsp_data  = fifo_mem_q[rd_ptr_q][WIDTH-1:0];
    assign rsp_op    = fifo_mem_q[rd_ptr_q][WIDTH+1:WIDTH];
    assign count     = count_q;

`ifdef ALU_SEQ_DRIVER_CHECK_EN
    logic [WIDTH-1:0] w_exp;
    logic             err_q;

    always_comb begin
        w_exp = '0;
        case (op_q)
            2'b00:   w_exp = ina_q + inb_q;
            2'b01:   w_exp = ina_q - inb_q;
            2'b10:   w_exp = ina_q & inb_q;
            default: w_exp = ina_q | inb_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (w_push && (alu_ans != w_exp)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire
